regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port (WEN_A/WA_A/W_DA) of the 16x32 general register file between two writeback sources.
- The sources are the execute stage (EX, ALU results) and the load unit (LD, memory read data).
- EX always has priority. Losing LD writes park in a small in-order pending buffer and drain in idle EX cycles.
- A pending-destination mask is exported so issue logic can stall on read-after-write hazards against parked loads.

Parameters:
DEPTH, 2, pending-buffer entries (power of two, 2..8)
CW, 2, width of PEND_CNT; must hold 0..DEPTH (CW = log2(DEPTH)+1)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
EX_WEN  input  1  EX write request, active-high, no handshake (always accepted)
EX_WA  input  4  EX destination register
EX_WD  input  32  EX write data
LD_VALID  input  1  LD write request
LD_WA  input  4  LD destination register
LD_WD  input  32  LD write data
LD_READY  output  1  LD request accepted this cycle when LD_VALID & LD_READY
WEN_A  output  1  register-file write enable, active-low, registered
WA_A  output  4  register-file write address, registered
W_DA  output  32  register-file write data, registered
PEND_MASK  output  16  bit i set when a live buffered entry targets register i
PEND_CNT  output  CW  number of occupied buffer entries, live or killed

Behaviour:
- Reset (RST=1 at an edge):
  - WEN_A=1, WA_A=0, W_DA=0.
  - Buffer emptied; PEND_MASK=0, PEND_CNT=0.
  - LD_READY=0 while RST is high.
  - Entries in flight are discarded and no write is issued.
  - In the first cycle after reset: LD_READY=1.
- LD_READY = (PEND_CNT != DEPTH). It is purely a function of registered state, with no combinational path from LD_VALID or EX_WEN.
- Per-cycle grant priority: EX request > buffer head > new LD request.
  - The buffer head is taken only when EX_WEN=0.
  - A new LD request bypasses the buffer only when EX_WEN=0 and the buffer is empty.
- Latency:
  - The granted request at cycle n drives WEN_A=0, WA_A and W_DA during cycle n+1.
  - The register file commits at the edge ending cycle n+1.
  - With no grant, WEN_A=1 in n+1 and WA_A/W_DA hold their previous values.
- Accepted LD not granted at cycle n: enqueued at the tail (live), even if the head pops in the same cycle. Pop and push in the same cycle leave PEND_CNT unchanged.
- Same-cycle conflict, EX_WEN & LD accepted & EX_WA==LD_WA:
  - EX is the younger write. The LD request is consumed (handshake completes) and dropped: not enqueued, never written.
- WAW kill: an EX grant to register X clears the live flag of every buffered entry with address X, in the same edge.
  - Killed entries keep their slot and are popped in order when they reach the head and the head is selected.
  - A killed head pop produces WEN_A=1 (a bubble) and still consumes its grant cycle.
- PEND_MASK: OR over live entries of the one-hot address. It is registered state, updated at the same edge as the enqueue, pop or kill.
- A buffer head pop is always in order. Buffer pointers wrap modulo DEPTH.
- Full buffer with EX_WEN=1 every cycle: LD_READY stays 0 and LD stalls indefinitely (no starvation guard by design). Issue logic guarantees EX bubbles.
- An EX write to a register with a pending LD entry is legal. An LD write to a register with a pending entry is legal; order is preserved by the buffer.

Test Plan:
- Reset with both requesters active -> WEN_A=1, PEND_MASK=0, LD_READY=0 during RST. LD_READY=1 in the first cycle after reset, and no write occurs in that cycle.
- LD_VALID, LD_WA=3, LD_WD=0xDEADBEEF, EX idle, empty buffer -> next cycle WEN_A=0, WA_A=3, W_DA=0xDEADBEEF, PEND_CNT stays 0.
- EX write r1=0x11 and LD write r2=0x22 in the same cycle:
  - The next cycle writes r1, with PEND_MASK=0x0004 and PEND_CNT=1.
  - The cycle after (EX idle) writes r2=0x22; PEND_MASK returns to 0.
- EX_WA=5 and LD_WA=5 in the same cycle -> a single write r5=EX_WD. The LD handshake completes, PEND_CNT=0, and r5 is never overwritten by the LD data.
- Load r7 parked, then EX writes r7=0x99:
  - PEND_MASK bit7 clears at that edge.
  - The later head pop produces WEN_A=1; the final r7 value is 0x99.
- EX_WEN=1 for 6 cycles while LD offers 3 requests, DEPTH=2:
  - LD_READY drops after 2 accepts and the third LD is held.
  - After EX stops, writes drain in order: head, head, then the held third LD.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 16x32 register file: EX always wins, losing loads
// park in an in-order buffer that drains when EX is idle.
module regfile_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EX_WEN,
  input  logic [3:0]    EX_WA,
  input  logic [31:0]   EX_WD,
  input  logic          LD_VALID,
  input  logic [3:0]    LD_WA,
  input  logic [31:0]   LD_WD,
  output logic          LD_READY,
  output logic          WEN_A,
  output logic [3:0]    WA_A,
  output logic [31:0]   W_DA,
  output logic [15:0]   PEND_MASK,
  output logic [CW-1:0] PEND_CNT
);

  localparam int PW = $clog2(DEPTH);

  logic [3:0]       buf_wa [DEPTH];
  logic [31:0]      buf_wd [DEPTH];
  logic [DEPTH-1:0] buf_live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic             ld_acc;
  logic             empty;
  logic             pop;
  logic             push;
  logic             bypass;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [DEPTH-1:0] live_n;
  logic [15:0]      mask_n;

  assign PEND_CNT = cnt;

  always_comb begin
    LD_READY = ~RST && (cnt != CW'(DEPTH));
    ld_acc   = LD_VALID & LD_READY;
    empty    = (cnt == '0);
    pop      = ~EX_WEN & ~empty;
    // A load colliding with a same-cycle EX write is older, so it is simply dropped.
    push     = ld_acc & (EX_WEN ? (LD_WA != EX_WA) : ~empty);
    bypass   = ld_acc & ~EX_WEN & empty;

    wr_en   = 1'b0;
    wr_addr = buf_wa[head];
    wr_data = buf_wd[head];
    if (EX_WEN) begin
      wr_en   = 1'b1;
      wr_addr = EX_WA;
      wr_data = EX_WD;
    end else if (pop) begin
      wr_en = buf_live[head];
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_addr = LD_WA;
      wr_data = LD_WD;
    end

    // Live flags double as occupancy for the mask: killed and empty slots are 0.
    live_n = buf_live;
    if (EX_WEN) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (buf_wa[i] == EX_WA) live_n[i] = 1'b0;
      end
    end
    if (pop)  live_n[head] = 1'b0;
    if (push) live_n[tail] = 1'b1;

    mask_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_n[i]) begin
        if (push && (tail == PW'(i))) mask_n[LD_WA] = 1'b1;
        else                          mask_n[buf_wa[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      buf_live  <= '0;
      PEND_MASK <= '0;
      WEN_A     <= 1'b1;
      WA_A      <= '0;
      W_DA      <= '0;
    end else begin
      buf_live  <= live_n;
      PEND_MASK <= mask_n;
      if (push) begin
        buf_wa[tail] <= LD_WA;
        buf_wd[tail] <= LD_WD;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      WEN_A <= ~wr_en;
      if (wr_en) begin
        WA_A <= wr_addr;
        W_DA <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: one task per scenario, expected values
// worked out by hand and compared inline.
module tb_regfile_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EX_WEN;
  logic [3:0]  EX_WA;
  logic [31:0] EX_WD;
  logic        LD_VALID;
  logic [3:0]  LD_WA;
  logic [31:0] LD_WD;
  logic        LD_READY;
  logic        WEN_A;
  logic [3:0]  WA_A;
  logic [31:0] W_DA;
  logic [15:0] PEND_MASK;
  logic [1:0]  PEND_CNT;

  int total = 0;
  int bad   = 0;
  logic [31:0] rf [16];

  regfile_wr_arbiter #(.DEPTH(2), .CW(2)) dut (
    .CLK(CLK), .RST(RST),
    .EX_WEN(EX_WEN), .EX_WA(EX_WA), .EX_WD(EX_WD),
    .LD_VALID(LD_VALID), .LD_WA(LD_WA), .LD_WD(LD_WD),
    .LD_READY(LD_READY),
    .WEN_A(WEN_A), .WA_A(WA_A), .W_DA(W_DA),
    .PEND_MASK(PEND_MASK), .PEND_CNT(PEND_CNT)
  );

  always #5 CLK = ~CLK;

  // Register file image, committed at the edge that ends a write cycle.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (WEN_A === 1'b0) begin
      rf[WA_A] <= W_DA;
    end
  end

  task automatic step_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EX_WEN = 0; EX_WA = 0; EX_WD = 0;
    LD_VALID = 0; LD_WA = 0; LD_WD = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    EX_WEN = 1; EX_WA = 4'd9; EX_WD = 32'h1234;
    LD_VALID = 1; LD_WA = 4'd2; LD_WD = 32'h5678;
    step_cycle();
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL reset_wen: got %b expected 1", WEN_A); end
    total++; if (WA_A !== 4'd0) begin bad++; $display("[TB] FAIL reset_wa: got %0d expected 0", WA_A); end
    total++; if (W_DA !== 32'h0) begin bad++; $display("[TB] FAIL reset_wd: got %h expected 0", W_DA); end
    total++; if (PEND_MASK !== 16'h0) begin bad++; $display("[TB] FAIL reset_mask: got %h expected 0", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d expected 0", PEND_CNT); end
    total++; if (LD_READY !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_during: got %b expected 0", LD_READY); end
    RST = 0;
    idle_inputs();
    #1;
    total++; if (LD_READY !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_after: got %b expected 1", LD_READY); end
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL reset_no_write: got %b expected 1", WEN_A); end
  endtask

  task automatic test_bypass();
    LD_VALID = 1; LD_WA = 4'd3; LD_WD = 32'hDEADBEEF;
    #1;
    total++; if (LD_READY !== 1'b1) begin bad++; $display("[TB] FAIL bypass_ready: got %b expected 1", LD_READY); end
    step_cycle();
    idle_inputs();
    total++; if (WEN_A !== 1'b0) begin bad++; $display("[TB] FAIL bypass_wen: got %b expected 0", WEN_A); end
    total++; if (WA_A !== 4'd3) begin bad++; $display("[TB] FAIL bypass_wa: got %0d expected 3", WA_A); end
    total++; if (W_DA !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL bypass_wd: got %h expected deadbeef", W_DA); end
    total++; if (PEND_CNT !== 2'd0) begin bad++; $display("[TB] FAIL bypass_cnt: got %0d expected 0", PEND_CNT); end
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL bypass_idle: got %b expected 1", WEN_A); end
  endtask

  task automatic test_ex_ld_conflict();
    EX_WEN = 1; EX_WA = 4'd1; EX_WD = 32'h11;
    LD_VALID = 1; LD_WA = 4'd2; LD_WD = 32'h22;
    step_cycle();
    idle_inputs();
    total++; if (WEN_A !== 1'b0) begin bad++; $display("[TB] FAIL conflict_ex_wen: got %b expected 0", WEN_A); end
    total++; if (WA_A !== 4'd1) begin bad++; $display("[TB] FAIL conflict_ex_wa: got %0d expected 1", WA_A); end
    total++; if (W_DA !== 32'h11) begin bad++; $display("[TB] FAIL conflict_ex_wd: got %h expected 11", W_DA); end
    total++; if (PEND_MASK !== 16'h0004) begin bad++; $display("[TB] FAIL conflict_mask: got %h expected 0004", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd1) begin bad++; $display("[TB] FAIL conflict_cnt: got %0d expected 1", PEND_CNT); end
    step_cycle();
    total++; if (WEN_A !== 1'b0) begin bad++; $display("[TB] FAIL conflict_ld_wen: got %b expected 0", WEN_A); end
    total++; if (WA_A !== 4'd2) begin bad++; $display("[TB] FAIL conflict_ld_wa: got %0d expected 2", WA_A); end
    total++; if (W_DA !== 32'h22) begin bad++; $display("[TB] FAIL conflict_ld_wd: got %h expected 22", W_DA); end
    total++; if (PEND_MASK !== 16'h0) begin bad++; $display("[TB] FAIL conflict_mask_clear: got %h expected 0", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd0) begin bad++; $display("[TB] FAIL conflict_cnt_clear: got %0d expected 0", PEND_CNT); end
  endtask

  task automatic test_same_dest();
    EX_WEN = 1; EX_WA = 4'd5; EX_WD = 32'h55;
    LD_VALID = 1; LD_WA = 4'd5; LD_WD = 32'h5A5A;
    #1;
    total++; if (LD_READY !== 1'b1) begin bad++; $display("[TB] FAIL same_ready: got %b expected 1", LD_READY); end
    step_cycle();
    idle_inputs();
    total++; if (WEN_A !== 1'b0) begin bad++; $display("[TB] FAIL same_wen: got %b expected 0", WEN_A); end
    total++; if (WA_A !== 4'd5) begin bad++; $display("[TB] FAIL same_wa: got %0d expected 5", WA_A); end
    total++; if (W_DA !== 32'h55) begin bad++; $display("[TB] FAIL same_wd: got %h expected 55", W_DA); end
    total++; if (PEND_CNT !== 2'd0) begin bad++; $display("[TB] FAIL same_cnt: got %0d expected 0", PEND_CNT); end
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL same_no_ld_write: got %b expected 1", WEN_A); end
    step_cycle();
    total++; if (rf[5] !== 32'h55) begin bad++; $display("[TB] FAIL same_r5: got %h expected 55", rf[5]); end
  endtask

  task automatic test_waw_kill();
    EX_WEN = 1; EX_WA = 4'd9; EX_WD = 32'h1;
    LD_VALID = 1; LD_WA = 4'd7; LD_WD = 32'h77;
    step_cycle();
    total++; if (PEND_MASK !== 16'h0080) begin bad++; $display("[TB] FAIL kill_parked_mask: got %h expected 0080", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd1) begin bad++; $display("[TB] FAIL kill_parked_cnt: got %0d expected 1", PEND_CNT); end
    LD_VALID = 0;
    EX_WA = 4'd7; EX_WD = 32'h99;
    step_cycle();
    idle_inputs();
    total++; if (PEND_MASK !== 16'h0) begin bad++; $display("[TB] FAIL kill_mask: got %h expected 0", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd1) begin bad++; $display("[TB] FAIL kill_slot_kept: got %0d expected 1", PEND_CNT); end
    total++; if (WA_A !== 4'd7 || W_DA !== 32'h99) begin bad++; $display("[TB] FAIL kill_ex_write: got %0d/%h expected 7/99", WA_A, W_DA); end
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL kill_bubble: got %b expected 1", WEN_A); end
    total++; if (PEND_CNT !== 2'd0) begin bad++; $display("[TB] FAIL kill_popped: got %0d expected 0", PEND_CNT); end
    total++; if (W_DA !== 32'h99) begin bad++; $display("[TB] FAIL kill_hold_wd: got %h expected 99", W_DA); end
    step_cycle();
    total++; if (rf[7] !== 32'h99) begin bad++; $display("[TB] FAIL kill_r7: got %h expected 99", rf[7]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ld_addr [3];
    logic [31:0] ld_data [3];
    int idx = 0;
    ld_addr[0] = 4'd4; ld_data[0] = 32'hA4;
    ld_addr[1] = 4'd6; ld_data[1] = 32'hB6;
    ld_addr[2] = 4'd8; ld_data[2] = 32'hC8;
    for (int k = 0; k < 6; k++) begin
      EX_WEN = 1; EX_WA = 4'(10 + k); EX_WD = 32'h100 + k;
      LD_VALID = 1; LD_WA = ld_addr[idx]; LD_WD = ld_data[idx];
      #1;
      total++; if (LD_READY !== (k < 2)) begin bad++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, LD_READY, (k < 2)); end
      if (k < 2) idx++;
      step_cycle();
      total++; if (WEN_A !== 1'b0 || WA_A !== 4'(10 + k) || W_DA !== 32'h100 + k) begin
        bad++; $display("[TB] FAIL b2b_ex[%0d]: got %b/%0d/%h expected 0/%0d/%h", k, WEN_A, WA_A, W_DA, 10 + k, 32'h100 + k);
      end
    end
    total++; if (PEND_MASK !== 16'h0050) begin bad++; $display("[TB] FAIL b2b_full_mask: got %h expected 0050", PEND_MASK); end
    total++; if (PEND_CNT !== 2'd2) begin bad++; $display("[TB] FAIL b2b_full_cnt: got %0d expected 2", PEND_CNT); end
    EX_WEN = 0;
    step_cycle();
    total++; if (WEN_A !== 1'b0 || WA_A !== 4'd4 || W_DA !== 32'hA4) begin bad++; $display("[TB] FAIL b2b_drain0: got %b/%0d/%h expected 0/4/a4", WEN_A, WA_A, W_DA); end
    total++; if (LD_READY !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_reopen: got %b expected 1", LD_READY); end
    step_cycle();
    LD_VALID = 0;
    total++; if (WEN_A !== 1'b0 || WA_A !== 4'd6 || W_DA !== 32'hB6) begin bad++; $display("[TB] FAIL b2b_drain1: got %b/%0d/%h expected 0/6/b6", WEN_A, WA_A, W_DA); end
    total++; if (PEND_CNT !== 2'd1 || PEND_MASK !== 16'h0100) begin bad++; $display("[TB] FAIL b2b_pushpop: got cnt=%0d mask=%h expected cnt=1 mask=0100", PEND_CNT, PEND_MASK); end
    step_cycle();
    total++; if (WEN_A !== 1'b0 || WA_A !== 4'd8 || W_DA !== 32'hC8) begin bad++; $display("[TB] FAIL b2b_drain2: got %b/%0d/%h expected 0/8/c8", WEN_A, WA_A, W_DA); end
    total++; if (PEND_CNT !== 2'd0 || PEND_MASK !== 16'h0) begin bad++; $display("[TB] FAIL b2b_empty: got cnt=%0d mask=%h expected 0/0", PEND_CNT, PEND_MASK); end
    idle_inputs();
    step_cycle();
  endtask

  task automatic test_reset_flush();
    EX_WEN = 1; EX_WA = 4'd15; EX_WD = 32'hF;
    LD_VALID = 1; LD_WA = 4'd1; LD_WD = 32'hE1;
    step_cycle();
    LD_WA = 4'd2; LD_WD = 32'hE2;
    step_cycle();
    total++; if (PEND_CNT !== 2'd2) begin bad++; $display("[TB] FAIL flush_pre_cnt: got %0d expected 2", PEND_CNT); end
    RST = 1;
    step_cycle();
    total++; if (PEND_CNT !== 2'd0 || PEND_MASK !== 16'h0) begin bad++; $display("[TB] FAIL flush_state: got cnt=%0d mask=%h expected 0/0", PEND_CNT, PEND_MASK); end
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL flush_wen: got %b expected 1", WEN_A); end
    RST = 0;
    idle_inputs();
    step_cycle();
    total++; if (WEN_A !== 1'b1) begin bad++; $display("[TB] FAIL flush_no_drain: got %b expected 1", WEN_A); end
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    test_reset();
    test_bypass();
    test_ex_ld_conflict();
    test_same_dest();
    test_waw_kill();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
